// File: rtl/mem_stage_lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store unit.
//   funct3 encodings, FSM state type, and address-alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  // HU only names a halfword access for loads; a store with that funct3 is a full word.
  function automatic logic is_half(input logic [2:0] f3, input logic store);
    return (f3 == F3_H) || (!store && (f3 == F3_HU));
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic store,
                                      input logic [1:0] lo);
    return (is_half(f3, store) && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
  endfunction

  // Natural alignment of the low address bits for the access size.
  function automatic logic [1:0] force_align(input logic [2:0] f3, input logic store,
                                             input logic [1:0] lo);
    logic [1:0] r;
    r = lo;
    if (f3 == F3_W)
      r = 2'b00;
    else if (is_half(f3, store))
      r = {lo[1], 1'b0};
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   funct3     in  access size / signedness
//   addr_lo    in  address bits [1:0]
//   store_data in  store operand
//   rdata      in  raw bus read word
//   wstrb      out byte enables for a store
//   wdata      out store data replicated across lanes
//   load_val   out selected lane, sign/zero extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wstrb = '1;
    wdata = store_data;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H: begin
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_val = rdata;
    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_val = {24'd0, byte_sel};
      F3_HU:   load_val = {16'd0, half_sel};
      default: load_val = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit. One bus transaction per memory
// instruction over a valid/ready request and valid response channel.
//   clk, reset (async, active-high)
//   addr_in, store_data_in, funct3_in, mem_read_in, mem_write_in, advance : from EX/MEM
//   stall_req    : hold IF..EX/MEM until the access completes
//   load_data    : aligned/extended load result (registered)
//   misalign_err : misaligned access trapped (only with LSU_MISALIGN_TRAP_EN)
//   req_valid/req_ready/req_we/req_addr/req_wdata/req_wstrb : request channel
//   resp_valid/resp_rdata : response channel (also acks stores)
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses;
// otherwise they are forced to natural alignment and misalign_err stays 0.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       store_data_in,
  input  logic [2:0]        funct3_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              advance,
  output logic              stall_req,
  output logic [31:0]       load_data,
  output logic              misalign_err,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  output logic [3:0]        req_wstrb,
  input  logic              resp_valid,
  input  logic [31:0]       resp_rdata
);

  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        op;
  logic        mis;
  logic [1:0]  eff_lo;
  logic [2:0]  sel_f3;
  logic [1:0]  sel_lo;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] load_val;

  assign op = mem_read_in | mem_write_in;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis    = op && misaligned(funct3_in, mem_write_in, addr_in[1:0]);
  assign eff_lo = addr_in[1:0];
`else
  assign mis    = 1'b0;
  assign eff_lo = force_align(funct3_in, mem_write_in, addr_in[1:0]);
`endif

  // One aligner serves both directions: in IDLE it shapes the incoming store,
  // afterwards it extracts the response using the latched access fields.
  assign sel_f3 = (state == IDLE) ? funct3_in : f3_q;
  assign sel_lo = (state == IDLE) ? eff_lo    : lo_q;

  lsu_align u_align (
    .funct3     (sel_f3),
    .addr_lo    (sel_lo),
    .store_data (store_data_in),
    .rdata      (resp_rdata),
    .wstrb      (wstrb),
    .wdata      (wdata),
    .load_val   (load_val)
  );

  assign stall_req = ((state == IDLE) && op) || (state == REQ) || (state == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      f3_q         <= '0;
      lo_q         <= '0;
      req_valid    <= 1'b0;
      req_we       <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_wstrb    <= '0;
      load_data    <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op) begin
            f3_q <= funct3_in;
            lo_q <= eff_lo;
            if (mis) begin
              state        <= DONE;
              misalign_err <= 1'b1;
              load_data    <= '0;
            end else begin
              state     <= REQ;
              req_valid <= 1'b1;
              req_we    <= mem_write_in;
              req_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
              req_wdata <= mem_write_in ? wdata : '0;
              req_wstrb <= mem_write_in ? wstrb : '0;
            end
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (resp_valid) begin
            if (!req_we)
              load_data <= load_val;
            state <= DONE;
          end
        end
        DONE: begin
          if (advance) begin
            misalign_err <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed self-checking bench for mem_stage_lsu.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_in, store_data_in, resp_rdata;
  logic [2:0]  funct3_in;
  logic        mem_read_in, mem_write_in, advance, req_ready, resp_valid;
  logic        stall_req, misalign_err, req_valid, req_we;
  logic [31:0] load_data, req_addr, req_wdata;
  logic [3:0]  req_wstrb;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .store_data_in(store_data_in),
    .funct3_in(funct3_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .advance(advance), .stall_req(stall_req), .load_data(load_data),
    .misalign_err(misalign_err), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0, miscompares = 0;

  // Model state: what the outputs must be in the current cycle.
  bit          model_on = 0;
  logic        exp_req_valid = 0, exp_we = 0, exp_mis = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_load = 0;
  logic [3:0]  exp_wstrb = 0;
  // Values captured from the DUT for literal checks.
  logic [31:0] cap_addr, cap_wdata, cap_load;
  logic [3:0]  cap_wstrb;
  logic        cap_we, cap_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_half(input logic [2:0] f3, input bit st);
    return (f3 == 3'd1) || (!st && f3 == 3'd5);
  endfunction

  function automatic bit m_trap(input logic [2:0] f3, input logic [31:0] a, input bit st);
    bit t = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    t = (m_half(f3, st) && (a % 2 != 0)) || (f3 == 3'd2 && (a % 4 != 0));
`endif
    return t;
  endfunction

  function automatic logic [31:0] m_addr(input logic [2:0] f3, input logic [31:0] a, input bit st);
    logic [31:0] r = a;
`ifndef LSU_MISALIGN_TRAP_EN
    if (f3 == 3'd2) r = a - (a % 4);
    else if (m_half(f3, st)) r = a - (a % 2);
`endif
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] b = (r >> (8 * (a % 4))) & 32'hFF;
    logic [31:0] h = (r >> (16 * ((a % 4) / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'h80) ? (b + 32'hFFFFFF00) : b;
      3'd1: return (h >= 32'h8000) ? (h + 32'hFFFF0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return r;
    endcase
  endfunction

  // Every cycle, away from the edge: outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (model_on && !reset) begin
        check("req_valid", req_valid, exp_req_valid);
        if (exp_req_valid) begin
          check("req_addr", req_addr, exp_addr);
          check("req_we", req_we, exp_we);
          check("req_wstrb", req_wstrb, exp_wstrb);
          check("req_wdata", req_wdata, exp_wdata);
        end
        check("load_data", load_data, exp_load);
        check("misalign_err", misalign_err, exp_mis);
      end
    end
  end

  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int unsigned ready_dly, input int unsigned hold);
    int unsigned stalls = 0;
    logic [31:0] ea = m_addr(f3, a, st);
    bit trap = m_trap(f3, a, st);
    @(negedge clk);
    mem_read_in = !st; mem_write_in = st; addr_in = a; store_data_in = d; funct3_in = f3;
    advance = 0; req_ready = 0; resp_valid = 0;
    exp_req_valid = 0; exp_mis = 0;
    #1 if (stall_req) stalls++;
    if (!trap) begin
      exp_we    = st;
      exp_addr  = ea - (ea % 4);
      exp_wstrb = !st ? 4'h0 : (f3 == 3'd0) ? 4'(1 << (ea % 4)) :
                  (f3 == 3'd1) ? 4'(3 << (2 * ((ea % 4) / 2))) : 4'hF;
      exp_wdata = !st ? 32'h0 : (f3 == 3'd0) ? (d & 32'hFF) * 32'h01010101 :
                  (f3 == 3'd1) ? (d & 32'hFFFF) * 32'h00010001 : d;
      @(negedge clk);                      // REQ
      exp_req_valid = 1;
      #1 if (stall_req) stalls++;
      cap_addr = req_addr; cap_wdata = req_wdata; cap_wstrb = req_wstrb; cap_we = req_we;
      for (int unsigned i = 0; i < ready_dly; i++) begin
        @(negedge clk);
        #1 if (stall_req) stalls++;
      end
      req_ready = 1;
      @(negedge clk);                      // WAIT
      req_ready = 0; exp_req_valid = 0;
      resp_valid = 1; resp_rdata = rd;
      #1 if (stall_req) stalls++;
      @(negedge clk);                      // DONE
      resp_valid = 0; resp_rdata = $urandom;
      if (!st) exp_load = m_load(f3, ea, rd);
    end else begin
      @(negedge clk);                      // DONE straight from IDLE
      exp_mis = 1; exp_load = 0;
    end
    #1 if (stall_req) stalls++;
    cap_mis = misalign_err; cap_load = load_data;
    check("stall_cycles", stalls, trap ? 32'd1 : 32'd3 + ready_dly);
    for (int unsigned i = 0; i < hold; i++) begin
      @(negedge clk);
      #1 check("done_hold_stall", stall_req, 0);
    end
    advance = 1;
    @(negedge clk);                        // IDLE
    advance = 0; mem_read_in = 0; mem_write_in = 0; exp_mis = 0;
    #1 check("idle_stall", stall_req, 0);
  endtask

  task automatic reset_mid(input bit in_wait);
    @(negedge clk);
    mem_read_in = 1; mem_write_in = 0; addr_in = 32'h2000; funct3_in = 3'd2;
    req_ready = 0; resp_valid = 0; advance = 0;
    exp_we = 0; exp_addr = 32'h2000; exp_wstrb = 0; exp_wdata = 0;
    @(negedge clk);                        // REQ
    exp_req_valid = 1;
    if (in_wait) begin
      req_ready = 1;
      @(negedge clk);                      // WAIT
      req_ready = 0; exp_req_valid = 0;
    end
    #1 reset = 1; mem_read_in = 0; exp_req_valid = 0; exp_load = 0;
    #1 check(in_wait ? "rst_wait_req_valid" : "rst_req_req_valid", req_valid, 0);
    check("rst_mid_stall", stall_req, 0);
    @(negedge clk);
    reset = 0;
    resp_valid = 1; resp_rdata = 32'h12345678;
    @(negedge clk);
    resp_valid = 0;
    #1 check("late_resp_load", load_data, 32'h0);
    check("late_resp_stall", stall_req, 0);
  endtask

  initial begin
    reset = 1; addr_in = 0; store_data_in = 0; funct3_in = 0; mem_read_in = 0;
    mem_write_in = 0; advance = 0; req_ready = 0; resp_valid = 0; resp_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_we", req_we, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_req_wdata", req_wdata, 0);
    check("rst_req_wstrb", req_wstrb, 0);
    check("rst_load_data", load_data, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_stall", stall_req, 0);
    reset = 0;
    model_on = 1;

    run_op(1, 3'd0, 32'h1003, 32'h000000AB, 32'h0, 0, 0);            // SB
    check("sb_addr", cap_addr, 32'h1000);
    check("sb_wstrb", cap_wstrb, 4'b1000);
    check("sb_wdata", cap_wdata, 32'hABABABAB);
    check("sb_we", cap_we, 1);

    run_op(0, 3'd0, 32'h1002, 0, 32'h80FF7F00, 0, 0);                // LB
    check("lb_lit", cap_load, 32'hFFFFFFFF);
    run_op(0, 3'd4, 32'h1002, 0, 32'h80FF7F00, 0, 0);                // LBU
    check("lbu_lit", cap_load, 32'h000000FF);
    run_op(0, 3'd1, 32'h1002, 0, 32'h80017F00, 0, 0);                // LH
    check("lh_lit", cap_load, 32'hFFFF8001);
    run_op(0, 3'd5, 32'h1002, 0, 32'h80017F00, 0, 0);                // LHU
    check("lhu_lit", cap_load, 32'h00008001);
    run_op(0, 3'd2, 32'h1000, 0, 32'h80017F00, 0, 0);                // LW
    check("lw_lit", cap_load, 32'h80017F00);

    run_op(1, 3'd1, 32'h1002, 32'h1234ABCD, 0, 4, 3);                // SH, slow ready, DONE hold
    check("sh_wstrb", cap_wstrb, 4'b1100);
    check("sh_wdata", cap_wdata, 32'hABCDABCD);
    check("store_keeps_load", cap_load, 32'h80017F00);
    run_op(1, 3'd2, 32'h1004, 32'hDEADBEEF, 0, 1, 0);                // SW
    run_op(0, 3'd0, 32'h1001, 0, 32'h00008000, 0, 1);                // LB lane 1
    check("lb_lane1_lit", cap_load, 32'hFFFFFF80);
    run_op(0, 3'd4, 32'h1000, 0, 32'h0000007F, 2, 0);                // LBU lane 0

    run_op(0, 3'd2, 32'h1001, 0, 32'hCAFEF00D, 0, 0);                // misaligned LW
`ifdef LSU_MISALIGN_TRAP_EN
    check("trap_mis", cap_mis, 1);
    check("trap_load", cap_load, 32'h0);
`else
    check("noTrap_addr", cap_addr, 32'h1000);
    check("noTrap_load", cap_load, 32'hCAFEF00D);
`endif
    run_op(0, 3'd1, 32'h1003, 0, 32'h8001FFFF, 0, 0);                // misaligned LH
    run_op(1, 3'd1, 32'h1001, 32'h00005A5A, 0, 0, 0);                // misaligned SH

    reset_mid(0);
    reset_mid(1);
    run_op(0, 3'd2, 32'h3000, 0, 32'h0BADC0DE, 0, 0);                // recovery
    check("recover_lit", cap_load, 32'h0BADC0DE);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage. It consumes the memory-control fields held in the EX/MEM pipeline register and runs one data-bus transaction per memory instruction over a valid/ready request channel and a valid response channel. It performs byte-lane alignment and load sign/zero extension, and holds the pipeline with `stall_req` until the access completes.

## Interface
- `ADDR_W`, 32: bus address width; `addr_in[ADDR_W-1:0]` is used, upper bits are ignored.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `addr_in` in 32: ALU result from EX/MEM (effective address).
- `store_data_in` in 32: store operand from EX/MEM.
- `funct3_in` in 3: `instr[14:12]` from EX/MEM.
- `mem_read_in` in 1: MemRead from EX/MEM.
- `mem_write_in` in 1: MemWrite from EX/MEM.
- `advance` in 1: the pipeline will capture EX/MEM outputs at this edge (no other stall source).
- `stall_req` out 1: hold IF..EX/MEM.
- `load_data` out 32: aligned and extended load result, valid in DONE.
- `misalign_err` out 1: misaligned access detected (see Configuration).
- `req_valid` out 1, `req_ready` in 1: request handshake.
- `req_we` out 1: 1 = store.
- `req_addr` out ADDR_W: word-aligned address, `{addr[ADDR_W-1:2], 2'b00}`.
- `req_wdata` out 32, `req_wstrb` out 4: store data replicated across lanes, and byte enables.
- `resp_valid` in 1, `resp_rdata` in 32: response or ack. Stores also wait for `resp_valid`.

## Operation
- A memory op exists when `mem_read_in | mem_write_in`. When both are set, the op is a store.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Op present: go to REQ and latch addr, data, funct3 and type.
  - Misaligned, with the macro defined: go to DONE instead.
  - No op: stay.
- REQ: `req_valid`=1 with stable latched fields. On `req_valid & req_ready`, go to WAIT.
- WAIT: on `resp_valid`, register the extracted load into `load_data` and go to DONE. For stores, `load_data` is unchanged.
- DONE: if `advance`, go to IDLE. Otherwise stay, so the same instruction is not reissued.
- `stall_req` = (IDLE & op present) | REQ | WAIT. It is 0 in DONE and in IDLE with no op.
- Stores:
  - SB: wstrb=`4'b0001<<addr[1:0]`, wdata=`{4{d[7:0]}}`.
  - SH: wstrb=`4'b0011<<{addr[1],1'b0}`, wdata=`{2{d[15:0]}}`.
  - SW and other funct3 values: wstrb=`4'b1111`, wdata=d.
- Loads: the selected byte or half comes from lane `addr[1:0]` or `addr[1]`.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW and undefined funct3: full word.
- `resp_valid` outside WAIT is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `req_valid`=0, `req_we`=0, `req_addr`=0, `req_wdata`=0, `req_wstrb`=0.
  - `load_data`=0, `misalign_err`=0.
  - `stall_req` is combinational, so it is 0 with no op present.
- Minimum latency with `req_ready`=1 and `resp_valid` in the cycle after the handshake:
  - Cycle 0: IDLE, stall.
  - Cycle 1: REQ, handshake.
  - Cycle 2: WAIT, response.
  - Cycle 3: DONE, stall=0.
  - Total: 3 stall cycles.
- `req_*` outputs are driven from registers. They are held constant while `req_valid & !req_ready`.
- Reset during REQ or WAIT: `req_valid` drops immediately and the state returns to IDLE. A late `resp_valid` is then ignored.
- `misalign_err` is high only in DONE for a misaligned op. In that case `load_data`=0 and no bus request is issued, giving 1 stall cycle.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - LH/LHU/SH with `addr[0]`=1 are misaligned.
  - LW/SW with `addr[1:0]`≠0 are misaligned.
  - Misaligned ops skip the bus and assert `misalign_err` in DONE.
- Undefined:
  - `misalign_err` is tied to 0.
  - Misaligned accesses are forced to natural alignment: halfword clears `addr[0]`, word clears `addr[1:0]`. They then proceed normally.

## Structure
- `lsu_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - `lsu_state_t` enum (IDLE, REQ, WAIT, DONE).
- Sub-module `lsu_align` (combinational) computes wstrb and wdata replication, plus load lane extraction and extension, from funct3, `addr[1:0]` and the data.
- The FSM and registers live in `mem_stage_lsu`.

## Test plan
- SB, `addr`=0x1003, data=0x000000AB → `req_addr`=0x1000, `req_wstrb`=4'b1000, `req_wdata`=0xABABABAB, `req_we`=1. `stall_req` is high for exactly 3 cycles.
- LB at 0x1002 with `resp_rdata`=0x80FF7F00 → `load_data`=0xFFFFFFFF. The same access as LBU → 0x000000FF.
- LH at 0x1002 with `resp_rdata`=0x80017F00 → 0xFFFF8001. LHU → 0x00008001. LW at 0x1000 → 0x80017F00.
- `req_ready` held low for 4 cycles in REQ → `req_*` are stable and `stall_req` stays 1. `advance`=0 in DONE → state stays DONE with no second request. `advance`=1 → IDLE.
- Reset asserted during WAIT → `req_valid`=0 and IDLE immediately. A subsequent `resp_valid` does not change `load_data`.
- With `LSU_MISALIGN_TRAP_EN`, LW at 0x1001 → no `req_valid`, `misalign_err`=1 for one cycle. Without the macro → `req_addr`=0x1000 and the access completes.
